// File: rtl/video_timing_gen_pkg.sv
// video_timing_gen_pkg
// Shared types and constants for the video timing generator:
//   - h_state_e / v_state_e : named horizontal and vertical line-segment states
//   - seg_e                 : axis-generic segment state used inside timing_axis
//   - 720p60 reference timing (1280/110/40/220, 720/5/5/20, positive syncs)
package video_timing_gen_pkg;

  typedef enum logic [1:0] {H_ACT, H_FP, H_SYNC, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYNC, V_BP} v_state_e;
  typedef enum logic [1:0] {SEG_ACT, SEG_FP, SEG_SYNC, SEG_BP} seg_e;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;
  localparam logic        H_POL_720P    = 1'b1;
  localparam logic        V_POL_720P    = 1'b1;

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
// Bundles the timing configuration and the generated timing outputs.
//   master : configuration source / timing consumer (drives reset, enable, widths, polarities)
//   slave  : timing generator side (drives x, y, syncs, den, frame_start, cfg_err)
// clk_in is the single pixel clock shared by both sides.
interface video_timing_gen_if #(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Y_BITS = 13
) (
  input logic clk_in
);
  logic              reset;
  logic              enable;
  logic [X_BITS-1:0] h_active, h_fp, h_sync, h_bp;
  logic [Y_BITS-1:0] v_active, v_fp, v_sync, v_bp;
  logic              h_pol, v_pol;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic              hn_out, vn_out, den_out, frame_start, cfg_err;

  modport master (
    input  clk_in,
    output reset, enable, h_active, h_fp, h_sync, h_bp,
           v_active, v_fp, v_sync, v_bp, h_pol, v_pol,
    input  x, y, hn_out, vn_out, den_out, frame_start, cfg_err
  );

  modport slave (
    input  clk_in, reset, enable, h_active, h_fp, h_sync, h_bp,
           v_active, v_fp, v_sync, v_bp, h_pol, v_pol,
    output x, y, hn_out, vn_out, den_out, frame_start, cfg_err
  );
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// timing_axis
// One timing axis: a position counter 0..total-1 plus a 4-state segment FSM
// (active, front porch, sync, back porch).
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : force position 0 / active segment (idle or frame restart)
//   step_i         : advance one position (wraps to 0 after total-1)
//   act_i..bp_i    : segment widths
//   cnt_o          : registered position
//   state_d_o      : segment of the position being loaded on the next edge
//   last_o         : current position is total-1
module timing_axis
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned W = 13
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         step_i,
  input  logic [W-1:0] act_i,
  input  logic [W-1:0] fp_i,
  input  logic [W-1:0] sync_i,
  input  logic [W-1:0] bp_i,
  output logic [W-1:0] cnt_o,
  output seg_e         state_d_o,
  output logic         last_o
);
  localparam int unsigned CW = W + 2;

  logic [CW-1:0] b_fp, b_sync, b_bp, total, cnt_inc;
  logic [W-1:0]  cnt_q, cnt_d;
  seg_e          state_q, state_d;

  // Segment start positions; widened so the sum of four widths cannot overflow
  assign b_fp    = CW'(act_i);
  assign b_sync  = b_fp + CW'(fp_i);
  assign b_bp    = b_sync + CW'(sync_i);
  assign total   = b_bp + CW'(bp_i);
  assign cnt_inc = CW'(cnt_q) + CW'(1);
  assign last_o  = (cnt_inc == total);

  // Transitions test the next position against every later boundary, so a
  // zero-width segment is jumped over in the same cycle.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (clear_i || (step_i && last_o)) begin
      cnt_d   = '0;
      state_d = SEG_ACT;
    end else if (step_i) begin
      cnt_d = cnt_inc[W-1:0];
      case (state_q)
        SEG_ACT: begin
          if (cnt_inc >= b_bp)        state_d = SEG_BP;
          else if (cnt_inc >= b_sync) state_d = SEG_SYNC;
          else if (cnt_inc >= b_fp)   state_d = SEG_FP;
        end
        SEG_FP: begin
          if (cnt_inc >= b_bp)        state_d = SEG_BP;
          else if (cnt_inc >= b_sync) state_d = SEG_SYNC;
        end
        SEG_SYNC: begin
          if (cnt_inc >= b_bp)        state_d = SEG_BP;
        end
        SEG_BP:  state_d = SEG_BP;
        default: state_d = SEG_ACT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      state_q <= SEG_ACT;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign state_d_o = state_d;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Programmable raster timing generator: horizontal and vertical counters with
// active / front porch / sync / back porch segments, registered and aligned
// outputs, frame-boundary shadowing of the timing inputs and config checking.
//   clk_in, reset        : pixel clock, synchronous active-high reset
//   enable               : run timing (low = idle at x=0,y=0, syncs inactive)
//   h_*/v_* widths, pols : timing configuration, captured at frame boundaries
//   x, y                 : current pixel position
//   hn_out, vn_out       : syncs at selected polarity
//   den_out              : active pixel
//   frame_start          : pulse on pixel (0,0)
//   cfg_err              : last captured configuration was illegal
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Y_BITS = 13
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [X_BITS-1:0] h_active,
  input  logic [X_BITS-1:0] h_fp,
  input  logic [X_BITS-1:0] h_sync,
  input  logic [X_BITS-1:0] h_bp,
  input  logic [Y_BITS-1:0] v_active,
  input  logic [Y_BITS-1:0] v_fp,
  input  logic [Y_BITS-1:0] v_sync,
  input  logic [Y_BITS-1:0] v_bp,
  input  logic              h_pol,
  input  logic              v_pol,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              hn_out,
  output logic              vn_out,
  output logic              den_out,
  output logic              frame_start,
  output logic              cfg_err
);
  localparam int unsigned XW = X_BITS + 2;
  localparam int unsigned YW = Y_BITS + 2;
  localparam logic [XW-1:0] X_MAX = {2'b00, {X_BITS{1'b1}}};
  localparam logic [YW-1:0] Y_MAX = {2'b00, {Y_BITS{1'b1}}};

  logic [X_BITS-1:0] h_act_q, h_fp_q, h_sync_q, h_bp_q;
  logic [Y_BITS-1:0] v_act_q, v_fp_q, v_sync_q, v_bp_q;
  logic              h_pol_q, v_pol_q;
  logic              run_q, run_d;
  logic              den_q, den_d, hs_q, hs_d, vs_q, vs_d, fs_q, err_q, err_d;

  logic [XW-1:0] h_tot_in;
  logic [YW-1:0] v_tot_in;
  logic          cfg_bad_in, h_last, v_last, frame_last, capture, start_pix, adv, ax_clear;
  logic          h_pol_eff, v_pol_eff;
  seg_e          h_seg_d, v_seg_d;
  h_state_e      h_st_d;
  v_state_e      v_st_d;

  assign h_tot_in   = XW'(h_active) + XW'(h_fp) + XW'(h_sync) + XW'(h_bp);
  assign v_tot_in   = YW'(v_active) + YW'(v_fp) + YW'(v_sync) + YW'(v_bp);
  assign cfg_bad_in = (h_tot_in > X_MAX) || (v_tot_in > Y_MAX) ||
                      (h_active == '0) || (v_active == '0);

  // While idle the shadows simply follow the inputs, so each idle cycle acts
  // as a capture point and a repaired config restarts on the next cycle.
  assign frame_last = run_q & h_last & v_last;
  assign capture    = ~run_q | frame_last;
  assign start_pix  = enable & capture & ~cfg_bad_in;
  assign adv        = enable & run_q & ~frame_last;
  assign run_d      = start_pix | adv;
  assign ax_clear   = reset | ~adv;
  assign h_pol_eff  = capture ? h_pol : h_pol_q;
  assign v_pol_eff  = capture ? v_pol : v_pol_q;

  timing_axis #(.W(X_BITS)) u_h_axis (
    .clk_i    (clk_in),
    .rst_i    (reset),
    .clear_i  (ax_clear),
    .step_i   (adv),
    .act_i    (h_act_q),
    .fp_i     (h_fp_q),
    .sync_i   (h_sync_q),
    .bp_i     (h_bp_q),
    .cnt_o    (x),
    .state_d_o(h_seg_d),
    .last_o   (h_last)
  );

  timing_axis #(.W(Y_BITS)) u_v_axis (
    .clk_i    (clk_in),
    .rst_i    (reset),
    .clear_i  (ax_clear),
    .step_i   (adv & h_last),
    .act_i    (v_act_q),
    .fp_i     (v_fp_q),
    .sync_i   (v_sync_q),
    .bp_i     (v_bp_q),
    .cnt_o    (y),
    .state_d_o(v_seg_d),
    .last_o   (v_last)
  );

  assign h_st_d = h_state_e'(h_seg_d);
  assign v_st_d = v_state_e'(v_seg_d);

  // Flag outputs are decoded from the axes' next state so they land in the
  // same cycle as the registered counters they describe.
  always_comb begin
    den_d = run_d & (h_st_d == H_ACT) & (v_st_d == V_ACT);
    hs_d  = (run_d && (h_st_d == H_SYNC)) ? h_pol_eff : ~h_pol_eff;
    vs_d  = (run_d && (v_st_d == V_SYNC)) ? v_pol_eff : ~v_pol_eff;
    err_d = (enable && capture) ? cfg_bad_in : err_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_act_q  <= h_active;
      h_fp_q   <= h_fp;
      h_sync_q <= h_sync;
      h_bp_q   <= h_bp;
      v_act_q  <= v_active;
      v_fp_q   <= v_fp;
      v_sync_q <= v_sync;
      v_bp_q   <= v_bp;
      h_pol_q  <= h_pol;
      v_pol_q  <= v_pol;
      run_q    <= 1'b0;
      den_q    <= 1'b0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
      hs_q     <= ~h_pol;
      vs_q     <= ~v_pol;
    end else begin
      if (capture) begin
        h_act_q  <= h_active;
        h_fp_q   <= h_fp;
        h_sync_q <= h_sync;
        h_bp_q   <= h_bp;
        v_act_q  <= v_active;
        v_fp_q   <= v_fp;
        v_sync_q <= v_sync;
        v_bp_q   <= v_bp;
        h_pol_q  <= h_pol;
        v_pol_q  <= v_pol;
      end
      run_q <= run_d;
      den_q <= den_d;
      fs_q  <= start_pix;
      err_q <= err_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign den_out     = den_q;
  assign hn_out      = hs_q;
  assign vn_out      = vs_q;
  assign frame_start = fs_q;
  assign cfg_err     = err_q;
endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.X_BITS(13), .Y_BITS(13)) vif (.clk_in(clk));

  video_timing_gen #(.X_BITS(13), .Y_BITS(13)) dut (
    .clk_in     (clk),
    .reset      (vif.reset),
    .enable     (vif.enable),
    .h_active   (vif.h_active),
    .h_fp       (vif.h_fp),
    .h_sync     (vif.h_sync),
    .h_bp       (vif.h_bp),
    .v_active   (vif.v_active),
    .v_fp       (vif.v_fp),
    .v_sync     (vif.v_sync),
    .v_bp       (vif.v_bp),
    .h_pol      (vif.h_pol),
    .v_pol      (vif.v_pol),
    .x          (vif.x),
    .y          (vif.y),
    .hn_out     (vif.hn_out),
    .vn_out     (vif.vn_out),
    .den_out    (vif.den_out),
    .frame_start(vif.frame_start),
    .cfg_err    (vif.cfg_err)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned den_n, hs_n, vs_n, fs_n, seq_err, hs_bad, vtog_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Samples n consecutive pixels starting with the one currently shown, which
  // must be (0,0); expects a raster of htot pixels per line.
  task automatic measure(input int unsigned n, input int unsigned htot,
                         input int unsigned hs_lo, input int unsigned hs_hi,
                         input logic hp, input logic vp);
    logic vprev;
    den_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; seq_err = 0; hs_bad = 0; vtog_bad = 0;
    vprev = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (vif.x !== 13'(i % htot) || vif.y !== 13'(i / htot)) seq_err++;
      if (vif.den_out === 1'b1) den_n++;
      if (vif.hn_out === hp) hs_n++;
      if ((vif.hn_out === hp) != (32'(vif.x) >= hs_lo && 32'(vif.x) <= hs_hi)) hs_bad++;
      if (vif.vn_out === vp) vs_n++;
      if (i > 0 && vif.vn_out !== vprev && vif.x != 13'd0) vtog_bad++;
      if (vif.frame_start === 1'b1) fs_n++;
      vprev = vif.vn_out;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.reset    = 1'b1;
    vif.enable   = 1'b1;
    vif.h_active = 13'd8; vif.h_fp = 13'd2; vif.h_sync = 13'd3; vif.h_bp = 13'd1;
    vif.v_active = 13'd4; vif.v_fp = 13'd1; vif.v_sync = 13'd2; vif.v_bp = 13'd1;
    vif.h_pol    = 1'b1;  vif.v_pol = 1'b1;
    step(3);

    // reset state
    chk("rst_x",   32'(vif.x), 32'd0);
    chk("rst_y",   32'(vif.y), 32'd0);
    chk("rst_den", 32'(vif.den_out), 32'd0);
    chk("rst_fs",  32'(vif.frame_start), 32'd0);
    chk("rst_err", 32'(vif.cfg_err), 32'd0);
    chk("rst_hn",  32'(vif.hn_out), 32'd0);
    chk("rst_vn",  32'(vif.vn_out), 32'd0);

    // first frame after release: 14 x 8 = 112 cycles
    vif.reset = 1'b0;
    step(1);
    chk("start_fs",  32'(vif.frame_start), 32'd1);
    chk("start_den", 32'(vif.den_out), 32'd1);
    measure(112, 14, 10, 12, 1'b1, 1'b1);
    chk("f1_seq",   seq_err, 32'd0);
    chk("f1_den",   den_n,   32'd32);
    chk("f1_hs",    hs_n,    32'd24);
    chk("f1_hsbad", hs_bad,  32'd0);
    chk("f1_vs",    vs_n,    32'd28);
    chk("f1_fs",    fs_n,    32'd1);
    chk("f2_fs",    32'(vif.frame_start), 32'd1);
    chk("f2_x",     32'(vif.x), 32'd0);

    // negative vertical polarity takes effect from the following frame
    vif.v_pol = 1'b0;
    step(112);
    measure(112, 14, 10, 12, 1'b1, 1'b0);
    chk("f3_seq",  seq_err,  32'd0);
    chk("f3_vs",   vs_n,     32'd28);
    chk("f3_vtog", vtog_bad, 32'd0);

    // disable mid-frame -> idle
    step(20);
    chk("mid_x", 32'(vif.x), 32'd6);
    vif.enable = 1'b0;
    step(1);
    chk("idle_x",   32'(vif.x), 32'd0);
    chk("idle_y",   32'(vif.y), 32'd0);
    chk("idle_den", 32'(vif.den_out), 32'd0);
    chk("idle_fs",  32'(vif.frame_start), 32'd0);
    chk("idle_hn",  32'(vif.hn_out), 32'd0);
    chk("idle_vn",  32'(vif.vn_out), 32'd1);
    step(3);
    chk("idle_hold_x", 32'(vif.x), 32'd0);

    // zero-width porches: h_total 11
    vif.h_fp = 13'd0; vif.h_bp = 13'd0;
    vif.enable = 1'b1;
    step(1);
    chk("nop_fs", 32'(vif.frame_start), 32'd1);
    measure(88, 11, 8, 10, 1'b1, 1'b0);
    chk("nop_seq",   seq_err, 32'd0);
    chk("nop_den",   den_n,   32'd32);
    chk("nop_hs",    hs_n,    32'd24);
    chk("nop_hsbad", hs_bad,  32'd0);
    chk("nop_fs2",   32'(vif.frame_start), 32'd1);

    // mid-frame change of h_active is deferred to the next frame
    vif.enable = 1'b0;
    vif.h_fp = 13'd2; vif.h_bp = 13'd1;
    step(1);
    vif.enable = 1'b1;
    step(1);
    step(28);
    chk("chg_y", 32'(vif.y), 32'd2);
    vif.h_active = 13'd6;
    step(7);
    chk("chg_old_x",   32'(vif.x), 32'd7);
    chk("chg_old_den", 32'(vif.den_out), 32'd1);
    step(77);
    chk("chg_fs", 32'(vif.frame_start), 32'd1);
    chk("chg_y0", 32'(vif.y), 32'd0);
    measure(96, 12, 8, 10, 1'b1, 1'b0);
    chk("new_seq",   seq_err, 32'd0);
    chk("new_den",   den_n,   32'd24);
    chk("new_hsbad", hs_bad,  32'd0);

    // h_active = 0 -> cfg_err at the end of this frame, repaired config restarts
    vif.h_active = 13'd0;
    step(96);
    chk("err_set", 32'(vif.cfg_err), 32'd1);
    chk("err_den", 32'(vif.den_out), 32'd0);
    chk("err_x",   32'(vif.x), 32'd0);
    chk("err_fs",  32'(vif.frame_start), 32'd0);
    step(5);
    chk("err_hold_x",   32'(vif.x), 32'd0);
    chk("err_hold_err", 32'(vif.cfg_err), 32'd1);
    vif.h_active = 13'd8;
    step(1);
    chk("err_clr",    32'(vif.cfg_err), 32'd0);
    chk("err_clr_fs", 32'(vif.frame_start), 32'd1);
    chk("err_clr_den", 32'(vif.den_out), 32'd1);

    // total overflow: 8191+2+3+1 > 8191; 8185+2+3+1 = 8191 is legal
    vif.enable = 1'b0;
    vif.h_active = 13'd8191;
    step(1);
    vif.enable = 1'b1;
    step(1);
    chk("ovf_err", 32'(vif.cfg_err), 32'd1);
    chk("ovf_fs",  32'(vif.frame_start), 32'd0);
    vif.h_active = 13'd8185;
    step(1);
    chk("max_err", 32'(vif.cfg_err), 32'd0);
    chk("max_fs",  32'(vif.frame_start), 32'd1);
    vif.enable = 1'b0;
    vif.h_active = 13'd8;
    step(1);
    vif.enable = 1'b1;
    step(1);

    // reset mid-frame at (5,2)
    step(33);
    chk("pre_rst_x", 32'(vif.x), 32'd5);
    chk("pre_rst_y", 32'(vif.y), 32'd2);
    vif.reset = 1'b1;
    step(1);
    chk("mrst_x",   32'(vif.x), 32'd0);
    chk("mrst_y",   32'(vif.y), 32'd0);
    chk("mrst_den", 32'(vif.den_out), 32'd0);
    chk("mrst_hn",  32'(vif.hn_out), 32'd0);
    chk("mrst_vn",  32'(vif.vn_out), 32'd1);
    vif.reset = 1'b0;
    step(1);
    chk("rel_fs",  32'(vif.frame_start), 32'd1);
    chk("rel_den", 32'(vif.den_out), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
